// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bus of the sequential binary-to-BCD converter.
// The master is the source of binary samples; the slave is the converter.
interface bin2bcd_seq_if #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_W-1:0]      bin_in;
   logic                  out_valid;
   logic [4*DIGITS-1:0]   bcd_out;
   logic [DIGITS-1:0]     blank;
   logic                  busy;

   modport master (
      output in_valid, bin_in,
      input  in_ready, out_valid, bcd_out, blank, busy
   );

   modport slave (
      input  in_valid, bin_in,
      output in_ready, out_valid, bcd_out, blank, busy
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock,
// one-cycle result strobe and a leading-zero blank mask for 7-segment drivers.
module bin2bcd_seq #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input logic          clk,
   input logic          rst,
   bin2bcd_seq_if.slave bus
);

   // Decimal digits needed for the largest BIN_W-bit value (2**BIN_W - 1).
   function automatic int min_digits(input int w);
      longint unsigned v;
      int              d;
      v = (64'd1 << w) - 64'd1;
      d = 1;
      v = v / 64'd10;
      while (v != 0) begin
         d++;
         v = v / 64'd10;
      end
      return d;
   endfunction

   if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
      $error("bin2bcd_seq: BIN_W=%0d outside 4..32", BIN_W);
   end
   if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
   end

   localparam int CNT_W = $clog2(BIN_W);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [BIN_W-1:0]    shreg;
   logic [BCD_W-1:0]    scratch;
   logic [BCD_W-1:0]    adj;
   logic [BCD_W-1:0]    scratch_nxt;
   logic [CNT_W-1:0]    cnt;
   logic                done;
   logic [DIGITS-1:0]   blank_nxt;
   logic                result_valid;
   logic [BCD_W-1:0]    result_bcd;
   logic [DIGITS-1:0]   result_blank;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path
   // through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = SHIFT;
         SHIFT:   if (cnt == '0)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready = (state == IDLE);
      bus.busy     = (state == SHIFT);
      done         = (state == SHIFT) && (cnt == '0);
   end

   // Add-3 correction on every digit, then shift the next binary bit in.
   always_comb begin
      adj = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
      scratch_nxt = {adj[BCD_W-2:0], shreg[BIN_W-1]};
   end

   // A digit blanks when it and every higher digit are zero; units never blank.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      blank_nxt  = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above   = zero_above && (scratch_nxt[4*i +: 4] == 4'd0);
         blank_nxt[i] = zero_above;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg        <= '0;
         scratch      <= '0;
         cnt          <= '0;
         result_valid <= 1'b0;
         result_bcd   <= '0;
         result_blank <= {{(DIGITS-1){1'b1}}, 1'b0};
      end else begin
         result_valid <= done;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  shreg   <= bus.bin_in;
                  scratch <= '0;
                  cnt     <= CNT_W'(BIN_W - 1);
               end
            end
            SHIFT: begin
               shreg   <= shreg << 1;
               scratch <= scratch_nxt;
               cnt     <= cnt - 1'b1;
               if (done) begin
                  result_bcd   <= scratch_nxt;
                  result_blank <= blank_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.out_valid = result_valid;
   assign bus.bcd_out   = result_bcd;
   assign bus.blank     = result_blank;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: directed 16-bit vectors plus model-checked
// sweeps of an 8-bit/3-digit and a 20-bit/7-digit instance.
module tb_bin2bcd_seq;

   typedef struct packed {
      logic [31:0] bcd;
      logic [7:0]  blank;
   } exp_t;

   logic clk    = 1'b0;
   logic rst16  = 1'b1;
   logic rst_sw = 1'b1;
   always #5 clk = ~clk;

   bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) m16 ();
   bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) m8 ();
   bin2bcd_seq_if #(.BIN_W(20), .DIGITS(7)) m20 ();

   bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (.clk(clk), .rst(rst16),  .bus(m16.slave));
   bin2bcd_seq #(.BIN_W(8),  .DIGITS(3)) dut8  (.clk(clk), .rst(rst_sw), .bus(m8.slave));
   bin2bcd_seq #(.BIN_W(20), .DIGITS(7)) dut20 (.clk(clk), .rst(rst_sw), .bus(m20.slave));

   exp_t q16[$];
   exp_t q8[$];
   exp_t q20[$];
   int   n_cmp     = 0;
   int   n_fail    = 0;
   int   strobes16 = 0;
   bit   done8     = 1'b0;
   bit   done20    = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Golden model: repeated division, independent of the shift-and-add method.
   function automatic logic [31:0] to_bcd(input int unsigned v, input int d);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [7:0] blank_model(input int unsigned v, input int d);
      logic [7:0]      b;
      longint unsigned p;
      b = '0;
      p = 1;
      for (int i = 1; i < d; i++) begin
         p = p * 10;
         b[i] = (longint'(v) < p);
      end
      return b;
   endfunction

   initial begin
      m16.in_valid = 1'b0; m16.bin_in = '0;
      m8.in_valid  = 1'b0; m8.bin_in  = '0;
      m20.in_valid = 1'b0; m20.bin_in = '0;
   end

   // Monitors: pop one expectation per result strobe.
   always @(negedge clk) begin
      if (m16.out_valid) begin
         strobes16++;
         if (q16.size() == 0) check("dut16_unexpected_strobe", 1, 0);
         else begin
            exp_t e;
            e = q16.pop_front();
            check("dut16_bcd",   64'(m16.bcd_out), 64'(e.bcd[19:0]));
            check("dut16_blank", 64'(m16.blank),   64'(e.blank[4:0]));
         end
      end
      if (m8.out_valid) begin
         if (q8.size() == 0) check("dut8_unexpected_strobe", 1, 0);
         else begin
            exp_t e;
            e = q8.pop_front();
            check("dut8_bcd",   64'(m8.bcd_out), 64'(e.bcd[11:0]));
            check("dut8_blank", 64'(m8.blank),   64'(e.blank[2:0]));
         end
      end
      if (m20.out_valid) begin
         if (q20.size() == 0) check("dut20_unexpected_strobe", 1, 0);
         else begin
            exp_t e;
            e = q20.pop_front();
            check("dut20_bcd",   64'(m20.bcd_out), 64'(e.bcd[27:0]));
            check("dut20_blank", 64'(m20.blank),   64'(e.blank[6:0]));
         end
      end
   end

   // Present a request and hold it until accepted; returns just after the accept edge.
   task automatic send16(input logic [15:0] v, input bit expect_result,
                         input logic [31:0] e_bcd, input logic [7:0] e_blank);
      logic r;
      int   t;
      exp_t e;
      if (expect_result) begin
         e.bcd   = e_bcd;
         e.blank = e_blank;
         q16.push_back(e);
      end
      m16.in_valid = 1'b1;
      m16.bin_in   = v;
      t = 0;
      do begin
         @(negedge clk);
         r = m16.in_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!r && t < 64);
      m16.in_valid = 1'b0;
      if (!r) check("dut16_accept_timeout", 0, 1);
   endtask

   task automatic run_one(input logic [15:0] v, input logic [31:0] e_bcd, input logic [7:0] e_blank);
      int n;
      int low;
      send16(v, 1'b1, e_bcd, e_blank);
      n   = 0;
      low = m16.in_ready ? 0 : 1;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (!m16.in_ready) low++;
      end while (!m16.out_valid && n < 64);
      check($sformatf("latency_%0d", v), 64'(n), 64'd16);
      check($sformatf("ready_low_%0d", v), 64'(low), 64'd16);
      @(posedge clk);
      #1;
      check($sformatf("strobe_width_%0d", v), 64'(m16.out_valid), 64'd0);
      check($sformatf("hold_%0d", v), 64'(m16.bcd_out), 64'(e_bcd[19:0]));
   endtask

   initial begin : main
      int n;
      int bad;
      int s;
      repeat (3) @(posedge clk);
      #1;
      rst16  = 1'b0;
      rst_sw = 1'b0;
      @(negedge clk);
      check("rst_in_ready",  64'(m16.in_ready),  64'd1);
      check("rst_busy",      64'(m16.busy),      64'd0);
      check("rst_out_valid", 64'(m16.out_valid), 64'd0);
      check("rst_bcd",       64'(m16.bcd_out),   64'h00000);
      check("rst_blank",     64'(m16.blank),     64'b11110);
      @(posedge clk);
      #1;

      run_one(16'd0,     32'h00000, 8'b11110);
      run_one(16'd65535, 32'h65535, 8'b00000);
      run_one(16'd255,   32'h00255, 8'b11000);
      run_one(16'd9,     32'h00009, 8'b11110);

      // Back-to-back: second request presented in the strobe cycle of the first.
      send16(16'd1234, 1'b1, 32'h01234, 8'b10000);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!m16.out_valid && n < 64);
      check("b2b_first_strobe", 64'(m16.out_valid), 64'd1);
      exp_t_push: begin
         exp_t e;
         e.bcd = 32'h04321; e.blank = 8'b10000;
         q16.push_back(e);
      end
      m16.in_valid = 1'b1;
      m16.bin_in   = 16'd4321;
      check("b2b_ready_in_strobe", 64'(m16.in_ready), 64'd1);
      n   = 0;
      bad = 0;
      do begin
         @(posedge clk);
         #1;
         m16.in_valid = 1'b0;
         n++;
         if (!m16.out_valid && m16.bcd_out !== 20'h01234) bad++;
      end while (!m16.out_valid && n < 64);
      check("b2b_gap", 64'(n), 64'd17);
      check("b2b_hold_errors", 64'(bad), 64'd0);
      @(posedge clk);
      #1;

      // Reset in the middle of a conversion: no strobe, reset values restored.
      send16(16'd40000, 1'b0, 32'h0, 8'h0);
      repeat (7) @(posedge clk);
      #1;
      rst16 = 1'b1;
      @(posedge clk);
      #1;
      rst16 = 1'b0;
      s = strobes16;
      check("abort_bcd",       64'(m16.bcd_out),   64'h00000);
      check("abort_blank",     64'(m16.blank),     64'b11110);
      check("abort_in_ready",  64'(m16.in_ready),  64'd1);
      check("abort_busy",      64'(m16.busy),      64'd0);
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_strobe", 64'(strobes16), 64'(s));
      run_one(16'd40000, 32'h40000, 8'b00000);

      n = 0;
      while (!(done8 && done20) && n < 40000) begin @(posedge clk); n++; end
      check("sweeps_finished", 64'(done8 && done20), 64'd1);
      repeat (30) @(posedge clk);
      check("q16_drained", 64'(q16.size()), 64'd0);
      check("q8_drained",  64'(q8.size()),  64'd0);
      check("q20_drained", 64'(q20.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin : sweep8
      int unsigned v;
      int   t;
      int   accepted;
      logic r;
      exp_t e;
      accepted = 0;
      wait (!rst_sw);
      @(posedge clk);
      #1;
      for (int i = 0; i < 1000; i++) begin
         v = (i == 0) ? 0 : (i == 1) ? 255 : $urandom_range(0, 255);
         e.bcd = to_bcd(v, 3); e.blank = blank_model(v, 3);
         q8.push_back(e);
         m8.in_valid = 1'b1;
         m8.bin_in   = v[7:0];
         t = 0;
         do begin @(negedge clk); r = m8.in_ready; @(posedge clk); #1; t++; end
         while (!r && t < 64);
         if (!r) break;
         accepted++;
      end
      m8.in_valid = 1'b0;
      check("sweep8_accepts", 64'(accepted), 64'd1000);
      done8 = 1'b1;
   end

   initial begin : sweep20
      int unsigned v;
      int   t;
      int   accepted;
      logic r;
      exp_t e;
      accepted = 0;
      wait (!rst_sw);
      @(posedge clk);
      #1;
      for (int i = 0; i < 1000; i++) begin
         v = (i == 0) ? 0 : (i == 1) ? 1048575 : $urandom_range(0, 1048575);
         e.bcd = to_bcd(v, 7); e.blank = blank_model(v, 7);
         q20.push_back(e);
         m20.in_valid = 1'b1;
         m20.bin_in   = v[19:0];
         t = 0;
         do begin @(negedge clk); r = m20.in_ready; @(posedge clk); #1; t++; end
         while (!r && t < 64);
         if (!r) break;
         accepted++;
      end
      m20.in_valid = 1'b0;
      check("sweep20_accepts", 64'(accepted), 64'd1000);
      done20 = 1'b1;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It processes one bit per clock with a per-digit "if ≥5 add 3" correction stage replicated across all DIGITS. It uses valid/ready input handshake, a one-cycle result strobe, and outputs a leading-zero blank mask. It feeds 7-segment display drivers for sensor readouts (e.g. ambient-light samples).

Parameters:
BIN_W, 16, width of binary input; legal range 4..32.
DIGITS, 5, number of BCD digits produced. Elaboration error if DIGITS < ceil(BIN_W·log10(2)).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  request to convert bin_in.
in_ready  out  1  high when a new request is accepted.
bin_in  in  BIN_W  unsigned binary value, sampled on accept.
out_valid  out  1  one-cycle strobe: bcd_out/blank updated.
bcd_out  out  4·DIGITS  packed BCD, digit 0 (units) at [3:0].
blank  out  DIGITS  1 = digit is a leading zero (display off).
busy  out  1  conversion in progress (inverse of in_ready).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, in_ready=1, busy=0, out_valid=0.
  - bcd_out=0, blank={DIGITS-1 ones, digit 0 = 0}.
  - Internal shift/count registers are cleared.
- FSM states: IDLE, SHIFT.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load shift reg = bin_in, scratch BCD = 0, cnt = BIN_W-1, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1. in_valid is ignored and bin_in is not sampled.
  - Each edge: every scratch digit ≥5 gets +3 (4-bit, no carry out). Then {scratch, shift reg} shifts left by 1, so the shift reg MSB enters scratch digit 0 bit 0.
  - cnt decrements each edge.
  - Edge with cnt==0: perform the final shift, write the shifted scratch to bcd_out, compute blank, assert out_valid for the next cycle, return to IDLE.
- Latency:
  - Accept at edge E0 → out_valid high during the cycle after edge E_BIN_W (BIN_W clocks).
  - Throughput is one conversion per BIN_W+1 cycles.
- Back-to-back: in_ready is high in the same cycle out_valid is high. A request accepted then starts immediately.
- Output hold: bcd_out/blank hold their last result until the next completion. out_valid is exactly one cycle wide.
- blank rule:
  - blank[i]=1 iff digit i and all higher digits are zero, for i ≥ 1.
  - blank[0] is always 0, so value 0 shows a single "0".
- Digit values: bcd_out digits are always 0..9. No overflow is possible given the DIGITS legality check.
- Reset mid-conversion aborts the conversion and restores reset values next cycle. No out_valid is produced for the aborted request.
- in_valid asserted during SHIFT is not queued. The source must hold in_valid until it sees in_ready.

Test Plan:
- After reset, check values with no stimulus: in_ready=1, out_valid=0, bcd_out=0x00000, blank=5'b11110.
- bin_in=0 → after 16 clocks out_valid=1 for 1 cycle; bcd_out=0x00000, blank=5'b11110.
- bin_in=65535 → bcd_out=0x65535, blank=5'b00000. Also check in_ready=0 for exactly 16 cycles.
- bin_in=255 → bcd_out=0x00255, blank=5'b11000. Then bin_in=9 → 0x00009, blank=5'b11110.
- Back-to-back: 1234 held valid, then 4321 presented in the out_valid cycle.
  - Expected results: 0x01234 then 0x04321.
  - Gap of exactly 17 cycles between strobes.
  - bcd_out holds 0x01234 between strobes.
- Reset and BIN_W sweep:
  - Assert rst at cycle 8 of a 40000 conversion → no out_valid, bcd_out=0. Next request 40000 → 0x40000.
  - Repeat a random sweep (1000 values) vs. a golden model for BIN_W=8/DIGITS=3 and BIN_W=20/DIGITS=7.
